reflet_float_cu_stacked: RTL

Parametrised control unit of the reflet floating-point CPU. It fetches 16-bit instructions, pulls multi-word immediates for SET and branch targets, and runs stack, branch, call/return and notification instructions. It adds a bounded return/data stack with overflow and underflow fault detection, and a conditional jump. It sits between instruction memory, the external stack RAM and the FPU register file.

---
 rtl/reflet_float_cu_stacked_if.sv | 40 ++++
 rtl/reflet_float_cu_stacked.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/reflet_float_cu_stacked_if.sv
// Memory-side bus of the stacked float control unit: instruction fetch port
// and external stack RAM port, grouped so both memories bind in one place.
//
// Bus semantics: both memories are asynchronous-read. inst_data_in must
// reflect the word at inst_addr in the same cycle, and stack_data_in the
// entry at stack_addr. There is no valid/ready pair on this bus. A stack
// write is a single-cycle strobe: the RAM captures stack_data_out at
// stack_addr on the rising clk edge where stack_write_en is high.
interface reflet_float_cu_stacked_if #(
  parameter int float_size  = 32,
  parameter int addr_size   = 32,
  parameter int stack_depth = 128
);
  localparam int stack_aw = $clog2(stack_depth);

  logic [addr_size-1:0]  inst_addr;
  logic [15:0]           inst_data_in;
  logic [stack_aw-1:0]   stack_addr;
  logic [float_size-1:0] stack_data_out;
  logic [float_size-1:0] stack_data_in;
  logic                  stack_write_en;

  modport master (
    output inst_addr,
    input  inst_data_in,
    output stack_addr,
    output stack_data_out,
    input  stack_data_in,
    output stack_write_en
  );

  modport slave (
    input  inst_addr,
    output inst_data_in,
    input  stack_addr,
    input  stack_data_out,
    output stack_data_in,
    input  stack_write_en
  );
endinterface

// File: rtl/reflet_float_cu_stacked.sv
// Control unit of the reflet floating-point CPU: fetches 16-bit instructions,
// gathers multi-word immediates, and executes stack, branch, call/return and
// notification instructions over a bounded stack with sticky fault reporting.
module reflet_float_cu_stacked #(
  parameter int float_size  = 32,
  parameter int addr_size   = 32,
  parameter int stack_depth = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_instruction_fetching,
  input  logic                  enable_execution,
  input  logic                  cmp_flag,
  input  logic [2:0]            ctrl_flag,
  output logic [15:0]           instruction,
  output logic                  ready,
  output logic [2:0]            notification,
  output logic [1:0]            fault,
  reflet_float_cu_stacked_if.master bus,
  input  logic [float_size-1:0] flt_in,
  output logic [float_size-1:0] flt_out,
  output logic [1:0]            debug_state
);

  // Opcode map, shared with the FPU decoder.
  localparam logic [5:0] OPP_NOP   = 6'd0;
  localparam logic [5:0] OPP_SET   = 6'd1;
  localparam logic [5:0] OPP_PUSH  = 6'd2;
  localparam logic [5:0] OPP_POP   = 6'd3;
  localparam logic [5:0] OPP_MOV   = 6'd4;
  localparam logic [5:0] OPP_JMP   = 6'd5;
  localparam logic [5:0] OPP_CALL  = 6'd6;
  localparam logic [5:0] OPP_RET   = 6'd7;
  localparam logic [5:0] OPP_NOTIF = 6'd8;
  localparam logic [5:0] OPP_JIF   = 6'd9;
  localparam logic [5:0] OPP_HALT  = 6'd10;

  localparam int NF     = float_size / 16;
  localparam int NA     = (addr_size + 15) / 16;
  localparam int NW     = (NF > NA) ? NF : NA;
  localparam int IMM_W  = NW * 16;
  localparam int CW     = (NW > 1) ? $clog2(NW) : 1;
  localparam int SAW    = $clog2(stack_depth);
  localparam int SPW    = SAW + 1;

  typedef enum logic [1:0] {S_FETCH, S_IMM, S_EXEC, S_FAULT} state_t;

  state_t                 state, state_n;
  logic [addr_size-1:0]   pc;
  logic [SPW-1:0]         sp;
  logic [SPW-1:0]         sp_dec;
  logic [CW-1:0]          cnt;
  logic [NW-1:0][15:0]    imm;
  logic [IMM_W-1:0]       imm_flat;
  logic [addr_size-1:0]   target;
  logic [5:0]             op;
  logic                   is_push, is_pop, ovf, udf, last_word, exec_go;

  function automatic logic has_imm(input logic [5:0] o);
    return (o == OPP_SET) || (o == OPP_JMP) || (o == OPP_JIF) || (o == OPP_CALL);
  endfunction

  assign op          = instruction[15:10];
  assign imm_flat    = imm;
  assign target      = imm_flat[addr_size-1:0];
  assign sp_dec      = sp - SPW'(1);
  assign is_push     = (op == OPP_PUSH) || (op == OPP_CALL);
  assign is_pop      = (op == OPP_POP) || (op == OPP_RET);
  assign ovf         = is_push && (sp == SPW'(stack_depth));
  assign udf         = is_pop && (sp == '0);
  assign last_word   = (op == OPP_SET) ? (int'(cnt) == NF - 1) : (int'(cnt) == NA - 1);
  assign exec_go     = (state == S_EXEC) && enable_execution;
  assign bus.inst_addr = pc;
  assign debug_state = state;

  // State register; reset returns to an instruction boundary.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_n;
  end

  // Next state plus all combinational outputs, gated so FAULT and stalls stay quiet.
  always_comb begin
    state_n            = state;
    ready              = 1'b0;
    notification       = 3'd0;
    bus.stack_write_en = 1'b0;
    bus.stack_addr     = is_push ? sp[SAW-1:0] : sp_dec[SAW-1:0];
    bus.stack_data_out = (op == OPP_CALL) ? float_size'(pc) : flt_in;
    case (state)
      S_FETCH: begin
        ready = 1'b1;
        if (enable_instruction_fetching)
          state_n = has_imm(bus.inst_data_in[15:10]) ? S_IMM : S_EXEC;
      end
      S_IMM: begin
        if (enable_instruction_fetching && last_word) state_n = S_EXEC;
      end
      S_EXEC: begin
        if (enable_execution) begin
          if (op == OPP_NOTIF) notification = ctrl_flag;
          bus.stack_write_en = is_push && !ovf;
          state_n = (ovf || udf || op == OPP_HALT) ? S_FAULT : S_FETCH;
        end
      end
      default: state_n = S_FAULT;
    endcase
  end

  // Datapath: PC, stack pointer, instruction/immediate latches, result and fault code.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= '0;
      sp          <= '0;
      cnt         <= '0;
      imm         <= '0;
      instruction <= '0;
      flt_out     <= '0;
      fault       <= 2'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (enable_instruction_fetching) begin
            instruction <= bus.inst_data_in;
            pc          <= pc + addr_size'(2);
            cnt         <= '0;
          end
        end
        S_IMM: begin
          if (enable_instruction_fetching) begin
            imm[cnt] <= bus.inst_data_in;
            pc       <= pc + addr_size'(2);
            cnt      <= cnt + CW'(1);
          end
        end
        S_EXEC: begin
          if (exec_go) begin
            if (ovf)      fault <= 2'd1;
            else if (udf) fault <= 2'd2;
            else begin
              case (op)
                OPP_PUSH: sp <= sp + SPW'(1);
                OPP_POP: begin
                  sp      <= sp_dec;
                  flt_out <= bus.stack_data_in;
                end
                OPP_MOV:  flt_out <= flt_in;
                OPP_SET:  flt_out <= imm_flat[float_size-1:0];
                OPP_JMP:  pc <= target;
                OPP_JIF:  if (cmp_flag) pc <= target;
                OPP_CALL: begin
                  sp <= sp + SPW'(1);
                  pc <= target;
                end
                OPP_RET: begin
                  sp <= sp_dec;
                  pc <= addr_size'(bus.stack_data_in);
                end
                OPP_HALT: fault <= 2'd3;
                default: ;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
